// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART word receiver.
// Contents:
//   WORD_W, BYTES_PER_WORD - assembled word geometry
//   byte_pos_t             - byte position within a word being assembled
//   uart_byte_t            - one received UART byte
//   rx_state_t             - bit-level receive FSM states used by uart_rx
package uart_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] byte_pos_t;
    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART byte receiver with a two-flop input synchronizer.
// Ports:
//   clk      - system clock
//   rstn     - synchronous active-low reset
//   rxd      - asynchronous serial input, idle high
//   rx_data  - last received byte, valid with rx_ready
//   rx_ready - one-cycle pulse per received byte
//   ferr     - stop bit of the byte reported with rx_ready was low
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 260
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output uart_byte_t rx_data,
    output logic       rx_ready,
    output logic       ferr
);

    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    rx_state_t  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0] r_bitIdx;
    uart_byte_t r_shift;

    // Synchronize rxd and keep one extra stage so a start bit is recognised
    // only on a real high-to-low edge. After a framing error the line may
    // still be low, and that must not be mistaken for a new start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Bit-level FSM: wait half a bit to reach mid-start, then sample every
    // full bit period for 8 data bits (LSB first) and the stop bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= RX_IDLE;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_prev && !r_sync2) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt    <= '0;
                        r_bitIdx <= '0;
                        r_state  <= r_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bitIdx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt    <= '0;
                        rx_ready <= 1'b1;
                        rx_data  <= r_shift;
                        ferr     <= !r_sync2;
                        r_state  <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// uart_word_rx: assembles received UART bytes (LSB first) into 32-bit words
// and queues them in a FIFO popped by the core with a valid/taken handshake.
// Ports:
//   clk, rstn       - clock and synchronous active-low reset
//   rxd             - serial input, 8N1, idle high
//   core_data       - FIFO head word (0 while empty)
//   core_data_valid - FIFO non-empty
//   core_data_taken - pop request, ignored while empty
//   word_count      - words currently stored
//   frame_err       - sticky: byte received with framing error
//   overflow        - sticky: completed word dropped, FIFO full
//   timeout_err     - sticky: partial word dropped on idle timeout
// Build option: define UART_RX_TIMEOUT_EN to enable the partial-word idle
// timeout; otherwise timeout_err is tied low and partial words wait forever.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 260,
    parameter int DEPTH_LOG2       = 6,
    parameter int TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rxd,
    output logic [WORD_W-1:0] core_data,
    output logic              core_data_valid,
    input  logic              core_data_taken,
    output logic [DEPTH_LOG2:0] word_count,
    output logic              frame_err,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam byte_pos_t LAST_POS = byte_pos_t'(BYTES_PER_WORD - 1);

    uart_byte_t w_rxData;
    logic       w_rxReady;
    logic       w_rxFerr;

    logic [WORD_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rdPtr;
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2:0] r_count;
    byte_pos_t           r_pos;
    logic [WORD_W-9:0]   r_partial;
    logic                r_frameErr;
    logic                r_overflow;

    logic              w_wordDone;
    logic [WORD_W-1:0] w_fullWord;
    logic              w_pop;
    logic              w_push;
    logic              w_timeoutHit;

    uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .rxd     (rxd),
        .rx_data (w_rxData),
        .rx_ready(w_rxReady),
        .ferr    (w_rxFerr)
    );

    // The top byte goes straight from the receiver into the pushed word, so
    // only the lower three bytes need holding.
    assign w_wordDone = w_rxReady && !w_rxFerr && (r_pos == LAST_POS);
    assign w_fullWord = {w_rxData, r_partial};
    assign w_pop      = core_data_taken && (r_count != '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push     = w_wordDone && ((r_count != FULL_COUNT) || w_pop);

    assign core_data       = (r_count == '0) ? '0 : r_mem[r_rdPtr];
    assign core_data_valid = (r_count != '0);
    assign word_count      = r_count;
    assign frame_err       = r_frameErr;
    assign overflow        = r_overflow;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] r_idleCnt;
    logic            r_timeoutErr;

    assign w_timeoutHit = (r_pos != '0) && (r_idleCnt == TO_LIMIT) && !w_rxReady;
    assign timeout_err  = r_timeoutErr;

    // Idle counter only runs with a partial word pending; it parks at the
    // limit once the word is discarded and restarts from the next byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idleCnt    <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (w_rxReady) begin
                r_idleCnt <= '0;
            end else if ((r_pos != '0) && (r_idleCnt != TO_LIMIT)) begin
                r_idleCnt <= r_idleCnt + 1'b1;
            end
            if (w_timeoutHit) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end
`else
    logic w_unusedTimeoutParam;

    // Keeps the parameter referenced when the timeout logic is compiled out.
    assign w_unusedTimeoutParam = (TIMEOUT_CYCLES != 0);
    assign w_timeoutHit         = 1'b0;
    assign timeout_err          = 1'b0;
`endif

    // Byte assembler: good bytes land by position; a framing error or an
    // idle timeout restarts the word. Stale partial bytes need no clearing
    // because every position is rewritten before the next push.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pos      <= '0;
            r_partial  <= '0;
            r_frameErr <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_rxReady) begin
                if (w_rxFerr) begin
                    r_pos      <= '0;
                    r_frameErr <= 1'b1;
                end else begin
                    case (r_pos)
                        2'd0:    r_partial[7:0]   <= w_rxData;
                        2'd1:    r_partial[15:8]  <= w_rxData;
                        2'd2:    r_partial[23:16] <= w_rxData;
                        default: ;
                    endcase
                    r_pos <= r_pos + 1'b1;
                end
            end else if (w_timeoutHit) begin
                r_pos <= '0;
            end
            if (w_wordDone && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the
    // count unchanged.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array has no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_fullWord;
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: scoreboard bench for uart_word_rx. Stimulus pushes each
// word it expects the core to receive; a monitor pops and compares whenever
// a word is handed over (valid and taken). Directed checks cover reset,
// latency, framing errors, overflow, full push+pop and the timeout option.
`timescale 1ns/1ps
module tb_uart_word_rx;

    localparam int HALF_BIT   = 2;
    localparam int BIT_CYCLES = 2 * HALF_BIT;
    localparam int DEPTH_LOG2 = 6;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              rxd = 1'b1;
    logic [31:0]       core_data;
    logic              core_data_valid;
    logic              core_data_taken = 1'b0;
    logic [DEPTH_LOG2:0] word_count;
    logic              frame_err;
    logic              overflow;
    logic              timeout_err;

    int checkCount = 0;
    int errorCount = 0;
    logic [31:0] expQ[$];
    bit popMode = 1'b0;
    bit armTake = 1'b0;

    uart_word_rx #(
        .CLK_PER_HALF_BIT(HALF_BIT),
        .DEPTH_LOG2      (DEPTH_LOG2),
        .TIMEOUT_CYCLES  (5000)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .rxd            (rxd),
        .core_data      (core_data),
        .core_data_valid(core_data_valid),
        .core_data_taken(core_data_taken),
        .word_count     (word_count),
        .frame_err      (frame_err),
        .overflow       (overflow),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    // Global time limit so the bench can never hang.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one 8N1 frame LSB first, then a two-bit idle gap.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        repeat (BIT_CYCLES) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (BIT_CYCLES) tick();
        end
        rxd = stopBit;
        repeat (BIT_CYCLES) tick();
        rxd = 1'b1;
        repeat (2 * BIT_CYCLES) tick();
    endtask

    task automatic sendWord(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(w[8*b +: 8], 1'b1);
        end
    endtask

    task automatic doReset();
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (4) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic drainFifo(input int budget);
        int n;
        n = 0;
        popMode = 1'b1;
        while ((expQ.size() != 0 || core_data_valid) && n < budget) begin
            tick();
            n++;
        end
        popMode = 1'b0;
        tick();
        tick();
        checkOutput("drain word_count", 32'(word_count), 32'd0);
        checkOutput("drain leftover expected words", 32'(expQ.size()), 32'd0);
    endtask

    // Single driver of core_data_taken, updated away from both clock edges.
    always @(posedge clk) begin
        #2;
        core_data_taken = popMode || (armTake && dut.w_rxReady);
    end

    // Monitor: every handed-over word is compared against the scoreboard.
    always @(negedge clk) begin
        if (rstn && core_data_valid && core_data_taken) begin
            if (expQ.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL scoreboard unexpected word: got 0x%08h expected none", core_data);
            end else begin
                checkOutput("scoreboard word", core_data, expQ.pop_front());
            end
        end
    end

    initial begin
        int seenValid;
        bit found;

        // Reset and idle
        doReset();
        checkOutput("reset valid", 32'(core_data_valid), 32'd0);
        checkOutput("reset word_count", 32'(word_count), 32'd0);
        checkOutput("reset core_data", core_data, 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        checkOutput("reset timeout_err", 32'(timeout_err), 32'd0);
        seenValid = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (core_data_valid) seenValid++;
        end
        checkOutput("idle valid cycles", 32'(seenValid), 32'd0);

        // Single word with push latency check
        applyStimulus(8'h78, 1'b1);
        applyStimulus(8'h56, 1'b1);
        applyStimulus(8'h34, 1'b1);
        expQ.push_back(32'h12345678);
        fork
            applyStimulus(8'h12, 1'b1);
            begin
                found = 1'b0;
                for (int i = 0; i < 20 * BIT_CYCLES && !found; i++) begin
                    @(negedge clk);
                    if (dut.w_rxReady) found = 1'b1;
                end
                checkOutput("4th byte ready seen", 32'(found), 32'd1);
                checkOutput("valid in push cycle", 32'(core_data_valid), 32'd0);
                @(negedge clk);
                checkOutput("valid after push", 32'(core_data_valid), 32'd1);
                checkOutput("count after push", 32'(word_count), 32'd1);
                checkOutput("head after push", core_data, 32'h12345678);
            end
        join
        popMode = 1'b1;
        tick();
        checkOutput("valid after pop", 32'(core_data_valid), 32'd0);
        checkOutput("count after pop", 32'(word_count), 32'd0);
        tick();
        tick();
        popMode = 1'b0;
        tick();
        checkOutput("pop while empty count", 32'(word_count), 32'd0);

        // Framing error discards the partial word
        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b0);
        expQ.push_back(32'hDEADBEEF);
        sendWord(32'hDEADBEEF);
        checkOutput("frame_err set", 32'(frame_err), 32'd1);
        checkOutput("frame count", 32'(word_count), 32'd1);
        drainFifo(50);

        // Reset in the middle of a word
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        doReset();
        checkOutput("mid-word reset frame_err", 32'(frame_err), 32'd0);
        expQ.push_back(32'h04030201);
        sendWord(32'h04030201);
        drainFifo(50);

        // Overflow
        doReset();
        for (int w = 0; w < DEPTH; w++) begin
            expQ.push_back(32'(w));
            sendWord(32'(w));
        end
        checkOutput("full count", 32'(word_count), 32'd64);
        checkOutput("full overflow clear", 32'(overflow), 32'd0);
        sendWord(32'hFFFFFFFF);
        checkOutput("overflow set", 32'(overflow), 32'd1);
        checkOutput("overflow count", 32'(word_count), 32'd64);
        checkOutput("overflow head", core_data, 32'h00000000);
        drainFifo(200);

        // Push and pop together while full
        doReset();
        for (int w = 0; w < DEPTH; w++) begin
            expQ.push_back(32'h100 + 32'(w));
            sendWord(32'h100 + 32'(w));
        end
        expQ.push_back(32'hCAFEF00D);
        applyStimulus(8'h0D, 1'b1);
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'hFE, 1'b1);
        armTake = 1'b1;
        applyStimulus(8'hCA, 1'b1);
        armTake = 1'b0;
        tick();
        checkOutput("full push+pop count", 32'(word_count), 32'd64);
        checkOutput("full push+pop overflow", 32'(overflow), 32'd0);
        checkOutput("full push+pop head", core_data, 32'h101);
        drainFifo(200);

        // Partial word idle behaviour
        doReset();
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
`ifdef UART_RX_TIMEOUT_EN
        repeat (6000) tick();
        checkOutput("timeout_err set", 32'(timeout_err), 32'd1);
        checkOutput("timeout count", 32'(word_count), 32'd0);
        expQ.push_back(32'h04030201);
        sendWord(32'h04030201);
`else
        repeat (200) tick();
        checkOutput("timeout_err tied low", 32'(timeout_err), 32'd0);
        expQ.push_back(32'h02012211);
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
`endif
        drainFifo(50);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
